// File: rtl/mem_load_return_queue_if.sv
// mem_load_return_queue_if: MEM request, data-bus response and WB result signals of the load-return queue
interface mem_load_return_queue_if #(
  parameter int TAGW = 5
);
  logic            req_valid;
  logic            req_ready;
  logic [6:0]      req_type;
  logic [1:0]      req_ea;
  logic [TAGW-1:0] req_tag;
  logic [31:0]     req_old;
  logic            data_ok;
  logic [31:0]     data_rdata;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [TAGW-1:0] out_tag;
  logic [31:0]     out_data;
  logic [3:0]      out_strb;
  logic            resp_err;
  modport master (
    output req_valid, req_type, req_ea, req_tag, req_old, data_ok, data_rdata, flush, out_ready,
    input  req_ready, out_valid, out_tag, out_data, out_strb, resp_err
  );
  modport slave (
    input  req_valid, req_type, req_ea, req_tag, req_old, data_ok, data_rdata, flush, out_ready,
    output req_ready, out_valid, out_tag, out_data, out_strb, resp_err
  );
endinterface

// File: rtl/mem_load_return_queue.sv
// mem_load_return_queue: in-order load-return queue between MEM and WB with flush and late-response dropping
module mem_load_return_queue #(
  parameter int DEPTH = 4,
  parameter int TAGW  = 5
) (
  input logic clk,
  input logic reset,
  mem_load_return_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW:0] CAP = (PW+1)'(DEPTH);
  logic [PW-1:0]   wr, rsp, rd, drop_cnt;
  logic [PW-1:0]   count, pending, flush_drop;
  logic [PW:0]     drop_sum;
  logic [DEPTH-1:0] done;
  logic [6:0]      type_q  [DEPTH];
  logic [1:0]      ea_q    [DEPTH];
  logic [TAGW-1:0] tag_q   [DEPTH];
  logic [31:0]     old_q   [DEPTH];
  logic [31:0]     rdata_q [DEPTH];
  logic            alloc, accept, retire, drop;
  logic [AW-1:0]   ri;
  logic [6:0]      t;
  logic [1:0]      a;
  logic [31:0]     d, o, ext, merged;
  logic [7:0]      bsel;
  logic [15:0]     hsel;
  logic [3:0]      strb;
  assign count    = wr - rd;
  assign pending  = wr - rsp;
  assign ri       = rd[AW-1:0];
  assign bus.req_ready = !bus.flush && ({1'b0, count} + {1'b0, drop_cnt} < CAP);
  assign alloc    = bus.req_valid && bus.req_ready;
  assign drop     = bus.data_ok && !bus.flush && drop_cnt != '0;
  assign accept   = bus.data_ok && !bus.flush && drop_cnt == '0 && pending != '0;
  assign bus.resp_err  = bus.data_ok && !bus.flush && drop_cnt == '0 && pending == '0;
  assign bus.out_valid = !bus.flush && count != '0 && done[ri];
  assign retire   = bus.out_valid && bus.out_ready;
  // every still-pending response becomes a late one to discard; a response in the flush cycle is one of them
  assign drop_sum   = {1'b0, drop_cnt} + {1'b0, pending};
  assign flush_drop = PW'(drop_sum - (PW+1)'(bus.data_ok && drop_sum != '0));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr       <= '0;
      rsp      <= '0;
      rd       <= '0;
      drop_cnt <= '0;
      done     <= '0;
    end else if (bus.flush) begin
      wr       <= '0;
      rsp      <= '0;
      rd       <= '0;
      drop_cnt <= flush_drop;
      done     <= '0;
    end else begin
      if (alloc) wr <= wr + 1'b1;
      if (accept) rsp <= rsp + 1'b1;
      if (retire) rd <= rd + 1'b1;
      if (drop) drop_cnt <= drop_cnt - 1'b1;
      if (retire) done[ri] <= 1'b0;
      if (accept) done[rsp[AW-1:0]] <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (alloc) begin
      type_q[wr[AW-1:0]] <= bus.req_type;
      ea_q[wr[AW-1:0]]   <= bus.req_ea;
      tag_q[wr[AW-1:0]]  <= bus.req_tag;
      old_q[wr[AW-1:0]]  <= bus.req_old;
    end
    if (accept) rdata_q[rsp[AW-1:0]] <= bus.data_rdata;
  end
  always_comb begin
    t      = type_q[ri];
    a      = ea_q[ri];
    d      = rdata_q[ri];
    o      = old_q[ri];
    bsel   = d[{a, 3'b000} +: 8];
    hsel   = a[1] ? d[31:16] : d[15:0];
    ext    = t[0] ? d :
             t[1] ? d << {~a, 3'b000} :
             t[2] ? d >> {a, 3'b000} :
             t[3] ? {{24{bsel[7]}}, bsel} :
             t[4] ? {24'h0, bsel} :
             t[5] ? {{16{hsel[15]}}, hsel} :
             t[6] ? {16'h0, hsel} : d;
    strb   = t[1] ? 4'b1111 << ~a : t[2] ? 4'b1111 >> a : 4'b1111;
    merged = o;
    for (int i = 0; i < 4; i++) merged[8*i +: 8] = strb[i] ? ext[8*i +: 8] : o[8*i +: 8];
  end
  assign bus.out_tag  = bus.out_valid ? tag_q[ri] : '0;
  assign bus.out_data = bus.out_valid ? merged : '0;
  assign bus.out_strb = bus.out_valid ? strb : '0;
endmodule

// File: tb/tb_mem_load_return_queue.sv
// tb_mem_load_return_queue: vector table, corner sequences and random traffic against a queue-based reference model
module tb_mem_load_return_queue;
  localparam int DEPTH = 4;
  localparam int TAGW  = 5;
  localparam logic [6:0] LW = 7'h01, LWL = 7'h02, LWR = 7'h04, LB = 7'h08, LBU = 7'h10, LH = 7'h20, LHU = 7'h40;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  mem_load_return_queue_if #(.TAGW(TAGW)) bus();
  mem_load_return_queue #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {
    logic [6:0]      ty;
    logic [1:0]      ea;
    logic [TAGW-1:0] tag;
    logic [31:0]     old;
    logic            done;
    logic [31:0]     rdata;
  } ent_t;
  typedef struct {
    logic rv; logic [6:0] ty; logic [1:0] ea; logic [TAGW-1:0] tag; logic [31:0] old;
    logic dok; logic [31:0] rdata; logic ordy;
    logic e_ready; logic e_valid; logic [TAGW-1:0] e_tag; logic [31:0] e_data; logic [3:0] e_strb; logic e_err;
  } vec_t;
  ent_t q[$];
  vec_t tbl[$];
  int drop = 0;
  int checks = 0;
  int failures = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic void ref_result(input ent_t e, output logic [31:0] data, output logic [3:0] strb);
    int v, n;
    logic [7:0] rb [4];
    for (int i = 0; i < 4; i++) rb[i] = e.rdata[8*i +: 8];
    data = e.old;
    strb = 4'hF;
    case (e.ty)
      LB, LBU: begin
        v = int'(rb[e.ea]);
        if (e.ty == LB && v >= 128) v -= 256;
        data = 32'(v);
      end
      LH, LHU: begin
        v = e.ea[1] ? int'(rb[3]) * 256 + int'(rb[2]) : int'(rb[1]) * 256 + int'(rb[0]);
        if (e.ty == LH && v >= 32768) v -= 65536;
        data = 32'(v);
      end
      LW: data = e.rdata;
      LWL: begin
        n = int'(e.ea) + 1;
        strb = 4'h0;
        for (int i = 0; i < 4; i++) if (i >= 4 - n) begin data[8*i +: 8] = rb[i - (4 - n)]; strb[i] = 1'b1; end
      end
      LWR: begin
        n = 4 - int'(e.ea);
        strb = 4'h0;
        for (int i = 0; i < 4; i++) if (i < n) begin data[8*i +: 8] = rb[i + int'(e.ea)]; strb[i] = 1'b1; end
      end
      default: ;
    endcase
  endfunction
  task automatic drive(input logic rv, input logic [6:0] ty, input logic [1:0] ea, input logic [TAGW-1:0] tag,
                       input logic [31:0] old, input logic dok, input logic [31:0] rdata, input logic fl, input logic ordy);
    bus.req_valid  = rv;
    bus.req_type   = ty;
    bus.req_ea     = ea;
    bus.req_tag    = tag;
    bus.req_old    = old;
    bus.data_ok    = dok;
    bus.data_rdata = rdata;
    bus.flush      = fl;
    bus.out_ready  = ordy;
    #1;
  endtask
  task automatic idle(input logic ordy);
    drive(1'b0, 7'h0, 2'd0, '0, 32'h0, 1'b0, 32'h0, 1'b0, ordy);
  endtask
  task automatic model_check();
    int pend = 0;
    logic ev = 1'b0;
    logic [31:0] ed = 32'h0;
    logic [3:0] es = 4'h0;
    logic [TAGW-1:0] et = '0;
    foreach (q[i]) if (!q[i].done) pend++;
    if (!bus.flush && q.size() > 0) ev = q[0].done;
    if (ev) begin ref_result(q[0], ed, es); et = q[0].tag; end
    chk("m_req_ready", bus.req_ready, !bus.flush && (q.size() + drop < DEPTH));
    chk("m_out_valid", bus.out_valid, ev);
    chk("m_out_tag", bus.out_tag, et);
    chk("m_out_data", bus.out_data, ed);
    chk("m_out_strb", bus.out_strb, es);
    chk("m_resp_err", bus.resp_err, bus.data_ok && !bus.flush && drop == 0 && pend == 0);
  endtask
  task automatic tick();
    int pend = 0;
    logic ret = 1'b0;
    logic acc;
    ent_t e;
    foreach (q[i]) if (!q[i].done) pend++;
    if (!bus.flush && q.size() > 0) ret = q[0].done && bus.out_ready;
    acc = bus.req_valid && !bus.flush && (q.size() + drop < DEPTH);
    if (bus.flush) begin
      drop = drop + pend - (bus.data_ok ? 1 : 0);
      if (drop < 0) drop = 0;
      q.delete();
    end else begin
      if (bus.data_ok) begin
        if (drop > 0) drop--;
        else for (int i = 0; i < q.size(); i++) if (!q[i].done) begin q[i].done = 1'b1; q[i].rdata = bus.data_rdata; break; end
      end
      if (ret) void'(q.pop_front());
      if (acc) begin
        e.ty = bus.req_type; e.ea = bus.req_ea; e.tag = bus.req_tag; e.old = bus.req_old; e.done = 1'b0; e.rdata = 32'h0;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic step();
    model_check();
    tick();
  endtask
  initial begin
    idle(1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(1'b0);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_tag", bus.out_tag, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_strb", bus.out_strb, 0);
    chk("rst_resp_err", bus.resp_err, 0);
    tick();
    // rv ty ea tag old dok rdata ordy | ready valid tag data strb err
    tbl.push_back('{1'b0, 7'h0, 2'd0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0});
    tbl.push_back('{1'b1, LB, 2'd2, 5'd3, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0});
    tbl.push_back('{1'b0, 7'h0, 2'd0, 5'd0, 32'h0, 1'b1, 32'h12803456, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0});
    tbl.push_back('{1'b0, 7'h0, 2'd0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 5'd3, 32'hFFFFFF80, 4'hF, 1'b0});
    tbl.push_back('{1'b1, LWL, 2'd1, 5'd7, 32'hAABBCCDD, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0});
    tbl.push_back('{1'b1, LWR, 2'd2, 5'd8, 32'hAABBCCDD, 1'b1, 32'h11223344, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0});
    tbl.push_back('{1'b0, 7'h0, 2'd0, 5'd0, 32'h0, 1'b1, 32'h11223344, 1'b0, 1'b1, 1'b1, 5'd7, 32'h3344CCDD, 4'hC, 1'b0});
    tbl.push_back('{1'b0, 7'h0, 2'd0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 5'd7, 32'h3344CCDD, 4'hC, 1'b0});
    tbl.push_back('{1'b0, 7'h0, 2'd0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 5'd8, 32'hAABB1122, 4'h3, 1'b0});
    tbl.push_back('{1'b0, 7'h0, 2'd0, 5'd0, 32'h0, 1'b1, 32'h0000FFFF, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 1'b1});
    tbl.push_back('{1'b0, 7'h0, 2'd0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0});
    tbl.push_back('{1'b1, LH, 2'd3, 5'd1, 32'h55555555, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0});
    tbl.push_back('{1'b1, LHU, 2'd0, 5'd2, 32'h55555555, 1'b1, 32'h80017FFF, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0});
    tbl.push_back('{1'b1, LBU, 2'd3, 5'd4, 32'h55555555, 1'b1, 32'h1234F00F, 1'b1, 1'b1, 1'b1, 5'd1, 32'hFFFF8001, 4'hF, 1'b0});
    tbl.push_back('{1'b0, 7'h0, 2'd0, 5'd0, 32'h0, 1'b1, 32'hAB000000, 1'b1, 1'b1, 1'b1, 5'd2, 32'h0000F00F, 4'hF, 1'b0});
    tbl.push_back('{1'b0, 7'h0, 2'd0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 5'd4, 32'h000000AB, 4'hF, 1'b0});
    tbl.push_back('{1'b1, LW, 2'd0, 5'd9, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0});
    tbl.push_back('{1'b0, 7'h0, 2'd0, 5'd0, 32'h0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0});
    tbl.push_back('{1'b0, 7'h0, 2'd0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 5'd9, 32'hDEADBEEF, 4'hF, 1'b0});
    foreach (tbl[i]) begin
      drive(tbl[i].rv, tbl[i].ty, tbl[i].ea, tbl[i].tag, tbl[i].old, tbl[i].dok, tbl[i].rdata, 1'b0, tbl[i].ordy);
      chk($sformatf("v%0d_req_ready", i), bus.req_ready, tbl[i].e_ready);
      chk($sformatf("v%0d_out_valid", i), bus.out_valid, tbl[i].e_valid);
      chk($sformatf("v%0d_out_tag", i), bus.out_tag, tbl[i].e_tag);
      chk($sformatf("v%0d_out_data", i), bus.out_data, tbl[i].e_data);
      chk($sformatf("v%0d_out_strb", i), bus.out_strb, tbl[i].e_strb);
      chk($sformatf("v%0d_resp_err", i), bus.resp_err, tbl[i].e_err);
      step();
    end
    // fill to DEPTH with WB stalled, answer all, then drain in order
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b1, LW, 2'd0, 5'(10 + k), 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      step();
    end
    idle(1'b0);
    chk("full_req_ready", bus.req_ready, 0);
    step();
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b1, LW, 2'd0, 5'd20, 32'h0, 1'b1, 32'h100 + 32'(k), 1'b0, 1'b0);
      chk("full_rsp_req_ready", bus.req_ready, 0);
      step();
    end
    for (int k = 0; k < DEPTH; k++) begin
      idle(1'b1);
      chk("drain_valid", bus.out_valid, 1);
      chk("drain_tag", bus.out_tag, 32'(10 + k));
      chk("drain_data", bus.out_data, 32'h100 + 32'(k));
      step();
    end
    idle(1'b0);
    chk("drain_req_ready", bus.req_ready, 1);
    chk("drain_empty", bus.out_valid, 0);
    step();
    // flush with two responses outstanding: the next two responses are stale
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, LW, 2'd0, 5'(k), 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 7'h0, 2'd0, '0, 32'h0, 1'b1, 32'h11111111, 1'b0, 1'b0);
    step();
    drive(1'b0, 7'h0, 2'd0, '0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("fl_out_valid", bus.out_valid, 0);
    chk("fl_req_ready", bus.req_ready, 0);
    step();
    drive(1'b1, LW, 2'd0, 5'd17, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("fl_new_ready", bus.req_ready, 1);
    step();
    drive(1'b0, 7'h0, 2'd0, '0, 32'h0, 1'b1, 32'hAAAA0000, 1'b0, 1'b1);
    chk("fl_drop_a_err", bus.resp_err, 0);
    step();
    drive(1'b0, 7'h0, 2'd0, '0, 32'h0, 1'b1, 32'hBBBB0000, 1'b0, 1'b1);
    chk("fl_drop_b_valid", bus.out_valid, 0);
    chk("fl_drop_b_err", bus.resp_err, 0);
    step();
    drive(1'b0, 7'h0, 2'd0, '0, 32'h0, 1'b1, 32'hCCCC0000, 1'b0, 1'b1);
    chk("fl_c_latency", bus.out_valid, 0);
    step();
    idle(1'b1);
    chk("fl_c_valid", bus.out_valid, 1);
    chk("fl_c_tag", bus.out_tag, 17);
    chk("fl_c_data", bus.out_data, 32'hCCCC0000);
    step();
    // flush coinciding with a response and a request, two pending
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, LW, 2'd0, 5'(k + 5), 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      step();
    end
    drive(1'b1, LW, 2'd0, 5'd30, 32'h0, 1'b1, 32'h12345678, 1'b1, 1'b1);
    chk("flr_req_ready", bus.req_ready, 0);
    chk("flr_out_valid", bus.out_valid, 0);
    chk("flr_resp_err", bus.resp_err, 0);
    step();
    drive(1'b0, 7'h0, 2'd0, '0, 32'h0, 1'b1, 32'h9ABCDEF0, 1'b0, 1'b1);
    chk("flr_dropped_err", bus.resp_err, 0);
    step();
    drive(1'b0, 7'h0, 2'd0, '0, 32'h0, 1'b1, 32'h0BADF00D, 1'b0, 1'b1);
    chk("stray_err", bus.resp_err, 1);
    chk("stray_valid", bus.out_valid, 0);
    step();
    idle(1'b1);
    chk("stray_err_pulse", bus.resp_err, 0);
    chk("stray_ready", bus.req_ready, 1);
    chk("stray_no_valid", bus.out_valid, 0);
    step();
    // asynchronous reset with a result waiting
    drive(1'b1, LHU, 2'd2, 5'd12, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    drive(1'b0, 7'h0, 2'd0, '0, 32'h0, 1'b1, 32'hFEDC0000, 1'b0, 1'b0);
    step();
    idle(1'b0);
    chk("pre_rst_valid", bus.out_valid, 1);
    reset = 1'b1;
    #1;
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_tag", bus.out_tag, 0);
    chk("arst_data", bus.out_data, 0);
    chk("arst_ready", bus.req_ready, 1);
    q.delete();
    drop = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      drive(($urandom % 3) != 0, 7'h1 << $urandom_range(6), 2'($urandom), 5'($urandom), $urandom,
            ($urandom % 2) == 0, $urandom, ($urandom % 20) == 0, ($urandom % 4) != 0);
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_load_return_queue.md
# mem_load_return_queue

In-order load-return queue between the MEM and WB stages. It records each issued load's type, byte offset, destination tag and old destination-register value, and accepts read responses from a split request/response data bus that cannot be back-pressured. It produces the sign- or zero-extended, lwl/lwr-merged register value with byte strobes, delivered to WB through a valid/ready handshake. It supports up to DEPTH outstanding loads and a pipeline flush that discards in-flight loads and drops their late responses.

## Interface
- DEPTH, 4, maximum entries; power of two, ≥2
- TAGW, 5, destination tag width
- clk  in  1  clock; everything samples on the rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  MEM issues a load this cycle
- req_ready  out  1  load accepted when req_valid&req_ready
- req_type  in  7  one-hot: [0] lw, [1] lwl, [2] lwr, [3] lb, [4] lbu, [5] lh, [6] lhu
- req_ea  in  2  effective address [1:0]
- req_tag  in  TAGW  destination register tag
- req_old  in  32  current destination register value (lwl/lwr merge source)
- data_ok  in  1  read response valid; always consumed, never stalled
- data_rdata  in  32  aligned response word
- flush  in  1  discard all queued loads
- out_valid  out  1  result available
- out_ready  in  1  WB accepts result
- out_tag  out  TAGW  tag of the result
- out_data  out  32  merged register value
- out_strb  out  4  bytes actually written by the load
- resp_err  out  1  one-cycle pulse: data_ok with nothing pending and nothing to drop

## Operation
- Storage is a circular buffer of DEPTH entries with three pointers: wr (allocate), rsp (next entry to receive data), rd (next entry to retire). Order is wr ≥ rsp ≥ rd (modulo). count = wr − rd; pending = wr − rsp.
- Allocate: on req_valid&req_ready, store type, ea, tag and old at wr, then wr+1.
- req_ready = !flush && (count + drop_cnt < DEPTH).
- Response handling on data_ok:
  - drop_cnt>0: decrement drop_cnt and discard the data.
  - otherwise, pending>0: write the data to the rsp entry, mark it done, rsp+1.
  - otherwise: discard and assert resp_err.
- Extraction:
  - lb/lbu select byte ea, sign/zero-extend; strb 1111.
  - lh/lhu select half ea[1] (ea[0] ignored; alignment exceptions are upstream), extend; strb 1111.
  - lw: word; strb 1111.
  - lwl ea=0..3: rdata[8(ea+1)−1:0] placed in the high bytes; strb 1000/1100/1110/1111.
  - lwr ea=0..3: rdata[31:8ea] placed in the low bytes; strb 1111/0111/0011/0001.
  - out_data = merged value: strobed bytes from the extracted data, remaining bytes from old.
- Retire: out_valid = rd entry done and count>0; out_* are driven from the rd entry. On out_valid&out_ready, rd+1.
- Flush (one cycle, highest priority):
  - all entries are invalidated; wr, rsp and rd are reset to equal; out_valid is 0 in the flush cycle.
  - drop_cnt_next = drop_cnt + pending − (data_ok ? 1 : 0), clamped at 0.
  - A data_ok in the flush cycle is treated as a dropped response.
  - No request is accepted in the flush cycle.
- Simultaneous allocate, response and retire in one cycle are all legal and are all performed.

## Timing
- Reset values: all pointers 0, drop_cnt 0, all done bits 0. Outputs: req_ready 1, out_valid 0, out_tag 0, out_data 0, out_strb 0, resp_err 0.
- Response-to-result latency is exactly 1 cycle: data_ok at edge N gives out_valid from cycle N+1 if that entry is at rd. There is no combinational bypass from data_rdata to out_data.
- out_* hold stable while out_valid && !out_ready.
- Full queue: req_ready=0 while responses keep being accepted. A retire in the same cycle does not raise req_ready combinationally; req_ready depends on registered state only, plus flush.
- Reset asserted mid-operation: everything returns to reset values immediately. Responses still outstanding in memory at that point are the system's responsibility; the bus is reset too.
- drop_cnt never exceeds DEPTH.

## Test plan
- Single lb, ea=2, rdata=0x12_80_34_56 -> one cycle after data_ok: out_data=0xFFFFFF80, strb=1111.
- lwl ea=1 old=0xAABBCCDD rdata=0x11223344, then lwr ea=2 with the same old and rdata -> 0x3344CCDD / 1100, then 0xAABB1122 / 0011.
- Fill DEPTH=4 loads with out_ready=0 -> req_ready=0 after the 4th. Send 4 data_ok, then raise out_ready -> 4 results in issue order on consecutive cycles, req_ready back to 1.
- Issue 3 loads, 1 response, flush -> drop_cnt=2. Issue 1 new load, then 3 data_ok with values A,B,C -> A and B dropped, only C is returned, tagged with the new load.
- Flush in the same cycle as data_ok and req_valid with 2 pending -> drop_cnt=1, request not accepted, no out_valid.
- data_ok with an empty queue and drop_cnt=0 -> resp_err pulses 1 cycle; state unchanged.
